// File: rtl/store_unit_pkg.sv
// Shared types and constants for the store path: FSM states and the store funct3 encodings.
package store_unit_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        MERGE = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } store_state_t;

    localparam logic [2:0] STORE_FUNCT3__SB = 3'b000;
    localparam logic [2:0] STORE_FUNCT3__SH = 3'b001;
    localparam logic [2:0] STORE_FUNCT3__SW = 3'b010;

endpackage

// File: rtl/store_merge.sv
// Combinational lane merge: replaces the byte/halfword lanes of an old word with store data.
module store_merge
    import store_unit_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] data,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    output logic [31:0] merged
);

    always_comb begin
        // NOTE: default first so every path assigns merged and no latch is inferred.
        merged = old_word;
        case (funct3)
            STORE_FUNCT3__SB: merged[{offset, 3'b000} +: 8] = data[7:0];
            STORE_FUNCT3__SH: begin
                // Offset 3 would straddle the word; the caller never presents it.
                if (offset != 2'd3) merged[{offset, 3'b000} +: 16] = data[15:0];
            end
            STORE_FUNCT3__SW: merged = data;
            default:          merged = old_word;
        endcase
    end

endmodule

// File: rtl/store_unit.sv
// Store unit: sb/sh/sw onto a word-only memory, read-modify-write for sub-word stores.
// Define STORE_MISALIGN_TRAP_EN to reject misaligned sh/sw instead of realigning them.
module store_unit
    import store_unit_pkg::*;
#(
    parameter int MEM_SIZE = 1024
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [2:0]  req_funct3,
    output logic        done,
    output logic        err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    input  logic [31:0] mem_rd
);

    localparam logic [32:0] ADDR_LIMIT = 33'(MEM_SIZE) << 2;

    store_state_t state, next_state;

    logic [31:0] data_q;
    logic [2:0]  funct3_q;
    logic [1:0]  offset_q;
    logic        err_q;
    logic [31:0] mem_addr_q;
    logic [31:0] merged_q;
    logic [31:0] merge_out;

    logic        accept;
    logic        funct3_legal;
    logic        in_range;
    logic        reject;
    logic [1:0]  offset_eff;

    assign accept       = req_valid && (state == IDLE);
    assign funct3_legal = (req_funct3 == STORE_FUNCT3__SB) || (req_funct3 == STORE_FUNCT3__SH) ||
                          (req_funct3 == STORE_FUNCT3__SW);
    assign in_range     = {1'b0, req_addr} < ADDR_LIMIT;

`ifdef STORE_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = ((req_funct3 == STORE_FUNCT3__SH) && (req_addr[1:0] == 2'd3)) ||
                        ((req_funct3 == STORE_FUNCT3__SW) && (req_addr[1:0] != 2'd0));
    assign reject     = !funct3_legal || !in_range || misaligned;
    assign offset_eff = req_addr[1:0];
`else
    // Misaligned sh at offset 3 folds onto the upper half; sw ignores the offset.
    assign reject     = !funct3_legal || !in_range;
    assign offset_eff = (req_funct3 == STORE_FUNCT3__SW) ? 2'd0 :
                        ((req_funct3 == STORE_FUNCT3__SH) && (req_addr[1:0] == 2'd3)) ? 2'd2 :
                        req_addr[1:0];
`endif

    store_merge u_merge (
        .old_word (mem_rd),
        .data     (data_q),
        .funct3   (funct3_q),
        .offset   (offset_q),
        .merged   (merge_out)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q     <= '0;
            funct3_q   <= '0;
            offset_q   <= '0;
            err_q      <= 1'b0;
            mem_addr_q <= '0;
            merged_q   <= '0;
        end else if (accept) begin
            data_q   <= req_data;
            funct3_q <= req_funct3;
            offset_q <= offset_eff;
            err_q    <= reject;
            if (!reject) mem_addr_q <= {req_addr[31:2], 2'b00};
            if (!reject && (req_funct3 == STORE_FUNCT3__SW)) merged_q <= req_data;
        end else if (state == MERGE) begin
            merged_q <= merge_out;
        end
    end

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        mem_we     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (reject)                                next_state = DONE;
                    else if (req_funct3 == STORE_FUNCT3__SW)   next_state = WRITE;
                    else                                       next_state = READ;
                end
            end
            READ:  next_state = MERGE;
            MERGE: next_state = WRITE;
            WRITE: begin
                mem_we     = 1'b1;
                next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                err        = err_q;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign mem_addr = mem_addr_q;
    assign mem_wd   = merged_q;

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit with a synchronous-read word memory model.
module tb_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [2:0]  req_funct3;
    logic        done;
    logic        err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    logic [31:0] mem [0:1023];
    int          we_count = 0;
    int          tests = 0;
    int          fails = 0;
    int          we_before;

    always #5 clk = ~clk;

    store_unit #(.MEM_SIZE(1024)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_funct3 (req_funct3),
        .done       (done),
        .err        (err),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .mem_we     (mem_we),
        .mem_rd     (mem_rd)
    );

    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            mem[mem_addr[11:2]] <= mem_wd;
            we_count <= we_count + 1;
        end
        mem_rd <= mem[mem_addr[11:2]];
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for one accept edge, then scrambles the inputs; returns at accept+1.
    task automatic issue(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3);
        req_valid  = 1'b1;
        req_addr   = addr;
        req_data   = data;
        req_funct3 = f3;
        tick();
        req_valid  = 1'b0;
        req_addr   = 32'hFFFF_FFFF;
        req_data   = 32'h5A5A_5A5A;
        req_funct3 = 3'b111;
    endtask

    task automatic do_sw(input logic [31:0] addr, input logic [31:0] data);
        issue(addr, data, 3'b010);
        tick();
        tick();
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_data   = '0;
        req_funct3 = '0;
        tick();
        tick();
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_wd", mem_wd, 32'h0);
        check("rst_addr", mem_addr, 32'h0);
        reset = 1'b0;
        tick();

        // sw: write at +1, done at +2
        issue(32'h10, 32'hDEADBEEF, 3'b010);
        check("sw_we", 32'(mem_we), 32'd1);
        check("sw_addr", mem_addr, 32'h10);
        check("sw_wd", mem_wd, 32'hDEADBEEF);
        check("sw_busy_ready", 32'(req_ready), 32'd0);
        check("sw_no_done_early", 32'(done), 32'd0);
        tick();
        check("sw_done", 32'(done), 32'd1);
        check("sw_err", 32'(err), 32'd0);
        check("sw_we_one_cycle", 32'(mem_we), 32'd0);
        tick();
        check("sw_idle_ready", 32'(req_ready), 32'd1);
        check("sw_done_pulse", 32'(done), 32'd0);
        check("sw_mem", mem[4], 32'hDEADBEEF);

        // sb into 0x11223344 at 0x20
        do_sw(32'h20, 32'h11223344);
        check("pre20", mem[8], 32'h11223344);
        issue(32'h22, 32'h000000AA, 3'b000);
        check("sb_read_addr", mem_addr, 32'h20);
        check("sb_read_we", 32'(mem_we), 32'd0);
        tick();
        check("sb_merge_we", 32'(mem_we), 32'd0);
        check("sb_merge_ready", 32'(req_ready), 32'd0);
        tick();
        check("sb_we", 32'(mem_we), 32'd1);
        check("sb_wd", mem_wd, 32'h11AA3344);
        tick();
        check("sb_done", 32'(done), 32'd1);
        check("sb_err", 32'(err), 32'd0);
        tick();
        check("sb_mem", mem[8], 32'h11AA3344);

        // sh at offset 1
        do_sw(32'h30, 32'h11223344);
        issue(32'h31, 32'h0000BEEF, 3'b001);
        tick();
        tick();
        check("sh1_we", 32'(mem_we), 32'd1);
        check("sh1_wd", mem_wd, 32'h11BEEF44);
        tick();
        check("sh1_done", 32'(done), 32'd1);
        tick();

        // sh at offset 0
        do_sw(32'h40, 32'h11223344);
        issue(32'h40, 32'h0000CAFE, 3'b001);
        tick();
        tick();
        check("sh0_wd", mem_wd, 32'h1122CAFE);
        tick();
        tick();
        check("sh0_mem", mem[16], 32'h1122CAFE);

        // sh at offset 3
        do_sw(32'h50, 32'h11223344);
        we_before = we_count;
        issue(32'h53, 32'h0000BEEF, 3'b001);
`ifdef STORE_MISALIGN_TRAP_EN
        check("sh3_done", 32'(done), 32'd1);
        check("sh3_err", 32'(err), 32'd1);
        check("sh3_we", 32'(mem_we), 32'd0);
        tick();
        check("sh3_no_write", 32'(we_count), 32'(we_before));
        check("sh3_mem", mem[20], 32'h11223344);
`else
        tick();
        tick();
        check("sh3_we", 32'(mem_we), 32'd1);
        check("sh3_wd", mem_wd, 32'hBEEF3344);
        tick();
        check("sh3_done", 32'(done), 32'd1);
        check("sh3_err", 32'(err), 32'd0);
        tick();
        check("sh3_mem", mem[20], 32'hBEEF3344);
`endif

        // illegal funct3 and out-of-range address
        we_before = we_count;
        issue(32'h10, 32'h12345678, 3'b011);
        check("f3_done", 32'(done), 32'd1);
        check("f3_err", 32'(err), 32'd1);
        check("f3_addr_hold", mem_addr, 32'h50);
        tick();
        issue(32'h0000_1000, 32'h12345678, 3'b010);
        check("oor_done", 32'(done), 32'd1);
        check("oor_err", 32'(err), 32'd1);
        tick();
        check("rej_no_write", 32'(we_count), 32'(we_before));
        check("rej_mem", mem[4], 32'hDEADBEEF);

        // back-to-back sw with req_valid held
        req_valid  = 1'b1;
        req_addr   = 32'h60;
        req_data   = 32'hA0A0A0A0;
        req_funct3 = 3'b010;
        tick();
        req_addr   = 32'h64;
        req_data   = 32'hB1B1B1B1;
        check("b2b_first_addr", mem_addr, 32'h60);
        check("b2b_first_wd", mem_wd, 32'hA0A0A0A0);
        check("b2b_ready_write", 32'(req_ready), 32'd0);
        tick();
        check("b2b_ready_done", 32'(req_ready), 32'd0);
        check("b2b_first_done", 32'(done), 32'd1);
        tick();
        check("b2b_ready_idle", 32'(req_ready), 32'd1);
        check("b2b_no_we_idle", 32'(mem_we), 32'd0);
        tick();
        req_valid = 1'b0;
        check("b2b_second_addr", mem_addr, 32'h64);
        check("b2b_second_wd", mem_wd, 32'hB1B1B1B1);
        tick();
        check("b2b_second_done", 32'(done), 32'd1);
        tick();
        check("b2b_mem0", mem[24], 32'hA0A0A0A0);
        check("b2b_mem1", mem[25], 32'hB1B1B1B1);

        // reset during MERGE of an sb
        do_sw(32'h70, 32'h11223344);
        we_before = we_count;
        issue(32'h71, 32'h00000055, 3'b000);
        tick();
        reset = 1'b1;
        #1;
        check("rstm_we", 32'(mem_we), 32'd0);
        check("rstm_ready", 32'(req_ready), 32'd1);
        check("rstm_done", 32'(done), 32'd0);
        check("rstm_addr", mem_addr, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        tick();
        check("rstm_no_write", 32'(we_count), 32'(we_before));
        check("rstm_mem", mem[28], 32'h11223344);

        // unit still functional after reset
        do_sw(32'h74, 32'h0BADF00D);
        check("post_rst_mem", mem[29], 32'h0BADF00D);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
